// File: rtl/instruction_sequencer.sv
// instruction_sequencer
//   Fetches instruction words from instruction memory, latches the opcode and
//   steps a 3-bit phase counter through each opcode's execute phases. It owns
//   the program counter: sequential increment on fetch, and JMP/BLT redirect
//   on retire. The opcode/state outputs feed the control matrix.
//
// Ports
//   clock        in   system clock, rising-edge active
//   reset_n      in   asynchronous active-low reset
//   instr_word   in   instruction word, sampled when fetch_req & instr_valid
//   instr_valid  in   memory data valid for address pc
//   LT_flag      in   ALU less-than, sampled on the edge leaving BLT phase 2
//   sm_reset     in   synchronous abort of the instruction in flight
//   halt         in   stop after the current instruction retires
//   fetch_req    out  instruction request, high only in state 0
//   pc           out  program counter
//   opcode       out  latched opcode (0000 for undefined opcodes and when halted)
//   state        out  0 fetch, 1-5 execute, 6 retire, 7 halted
//   branch_taken out  pulse in state 6 when pc is redirected
//   instr_done   out  pulse in state 6 for each retired/aborted instruction
//   illegal_op   out  pulse in the slot after an undefined opcode is fetched
module instruction_sequencer #(
    parameter int          INSTR_W  = 16,
    parameter int          PC_W     = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [INSTR_W-1:0] instr_word,
    input  logic               instr_valid,
    input  logic               LT_flag,
    input  logic               sm_reset,
    input  logic               halt,
    output logic               fetch_req,
    output logic [PC_W-1:0]    pc,
    output logic [3:0]         opcode,
    output logic [2:0]         state,
    output logic               branch_taken,
    output logic               instr_done,
    output logic               illegal_op
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_EX1    = 3'd1,
        S_EX2    = 3'd2,
        S_EX3    = 3'd3,
        S_EX4    = 3'd4,
        S_EX5    = 3'd5,
        S_RETIRE = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    localparam logic [3:0] OP_JMP = 4'b0001;
    localparam logic [3:0] OP_BLT = 4'b0101;

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_opcode;
    logic [2:0]        r_last;
    logic [PC_W-1:0]   r_pc;
    logic [PC_W-1:0]   r_target;
    logic              r_fetch_req;
    logic              r_branch_taken;
    logic              r_instr_done;
    logic              r_illegal_op;

    logic [3:0]        w_fetch_op;
    logic [2:0]        w_fetch_last;
    logic              w_accept;
    logic              w_exec;
    logic              w_exec_end;
    logic              w_unused_operand;

    assign w_fetch_op = instr_word[INSTR_W-1 -: 4];
    assign w_accept   = (r_state == S_FETCH) && instr_valid && !sm_reset;
    assign w_exec     = (r_state >= S_EX1) && (r_state <= S_EX5);
    assign w_exec_end = w_exec && !sm_reset && (r_state == r_last);

    // Operand bits above the PC width have no consumer in this block.
    assign w_unused_operand = ^instr_word;

    // Last execute phase per opcode; 0 means retire directly after fetch.
    always_comb begin
        w_fetch_last = 3'd0;
        case (w_fetch_op)
            4'b0001:                   w_fetch_last = 3'd1;
            4'b0010, 4'b0011:          w_fetch_last = 3'd3;
            4'b0100, 4'b0101:          w_fetch_last = 3'd2;
            4'b0110, 4'b0111:          w_fetch_last = 3'd3;
            default:                   w_fetch_last = 3'd0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH: begin
                if (sm_reset)
                    w_next = S_RETIRE;
                else if (instr_valid)
                    w_next = (w_fetch_op[3] || (w_fetch_last == 3'd0)) ? S_RETIRE : S_EX1;
            end
            S_EX1, S_EX2, S_EX3, S_EX4, S_EX5: begin
                if (sm_reset || (r_state == r_last))
                    w_next = S_RETIRE;
                else
                    w_next = state_t'(r_state + 3'd1);
            end
            S_RETIRE, S_HALT: w_next = halt ? S_HALT : S_FETCH;
            default:          w_next = S_RETIRE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_state <= S_RETIRE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pc           <= PC_W'(RESET_PC);
            r_opcode       <= '0;
            r_last         <= '0;
            r_target       <= '0;
            r_fetch_req    <= 1'b0;
            r_branch_taken <= 1'b0;
            r_instr_done   <= 1'b0;
            r_illegal_op   <= 1'b0;
        end else begin
            r_fetch_req    <= (w_next == S_FETCH);
            // The reset-exit pass through state 6 comes from state 6, so it
            // never raises instr_done.
            r_instr_done   <= ((r_state == S_FETCH) || w_exec) && (w_next == S_RETIRE);
            // branch_taken is registered on entry to state 6, so the BLT
            // decision uses LT_flag on the same edge that samples it.
            r_branch_taken <= w_exec_end &&
                              ((r_opcode == OP_JMP) || ((r_opcode == OP_BLT) && LT_flag));
            r_illegal_op   <= w_accept && w_fetch_op[3];

            if (w_accept) begin
                r_pc     <= r_pc + 1'b1;
                r_opcode <= w_fetch_op[3] ? 4'b0000 : w_fetch_op;
                r_last   <= w_fetch_last;
                r_target <= instr_word[PC_W-1:0];
            end else if ((r_state == S_RETIRE) && r_branch_taken) begin
                r_pc <= r_target;
            end

            if (w_next == S_HALT)
                r_opcode <= '0;
        end
    end

    assign fetch_req    = r_fetch_req;
    assign pc           = r_pc;
    assign opcode       = r_opcode;
    assign state        = r_state;
    assign branch_taken = r_branch_taken;
    assign instr_done   = r_instr_done;
    assign illegal_op   = r_illegal_op;

endmodule

// File: tb/tb_instruction_sequencer.sv
// tb_instruction_sequencer
//   Directed stimulus for instruction_sequencer. An instruction-level model
//   tracks the expected outputs and is compared on every falling clock edge;
//   literal checks in the stimulus pin the model to hand-computed values.
module tb_instruction_sequencer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [15:0] instr_word;
    logic        instr_valid;
    logic        LT_flag;
    logic        sm_reset;
    logic        halt;
    logic        fetch_req;
    logic [7:0]  pc;
    logic [3:0]  opcode;
    logic [2:0]  state;
    logic        branch_taken;
    logic        instr_done;
    logic        illegal_op;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    instruction_sequencer #(.INSTR_W(16), .PC_W(8), .RESET_PC(0)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .instr_word   (instr_word),
        .instr_valid  (instr_valid),
        .LT_flag      (LT_flag),
        .sm_reset     (sm_reset),
        .halt         (halt),
        .fetch_req    (fetch_req),
        .pc           (pc),
        .opcode       (opcode),
        .state        (state),
        .branch_taken (branch_taken),
        .instr_done   (instr_done),
        .illegal_op   (illegal_op)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- instruction-level model ----------------
    // Each opcode is described by how many execute cycles it occupies; the
    // model counts down the remaining cycles rather than tracking phases.
    int cycles_tbl [8] = '{0, 1, 3, 3, 2, 2, 3, 3};
    int m_state, m_pc, m_op, m_target, m_left;
    int m_done, m_taken, m_ill;
    int m_redirect;
    int m_fop;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_state = 6; m_pc = 0; m_op = 0; m_target = 0; m_left = 0;
            m_done = 0; m_taken = 0; m_ill = 0;
        end else begin
            m_redirect = m_taken;
            m_done = 0; m_taken = 0; m_ill = 0;
            if (m_state == 0) begin
                if (sm_reset) begin
                    m_state = 6; m_done = 1;
                end else if (instr_valid) begin
                    m_fop    = instr_word / 4096;
                    m_pc     = (m_pc + 1) % 256;
                    m_target = instr_word % 256;
                    if (m_fop >= 8) begin
                        m_ill = 1; m_op = 0; m_left = 0;
                    end else begin
                        m_op = m_fop; m_left = cycles_tbl[m_fop];
                    end
                    if (m_left == 0) begin
                        m_state = 6; m_done = 1;
                    end else begin
                        m_state = 1; m_left = m_left - 1;
                    end
                end
            end else if (m_state <= 5) begin
                if (sm_reset) begin
                    m_state = 6; m_done = 1;
                end else if (m_left == 0) begin
                    m_state = 6; m_done = 1;
                    m_taken = (m_op == 1) || (m_op == 5 && LT_flag) ? 1 : 0;
                end else begin
                    m_state = m_state + 1; m_left = m_left - 1;
                end
            end else begin
                if (m_state == 6 && m_redirect != 0) m_pc = m_target;
                if (halt) begin
                    m_state = 7; m_op = 0;
                end else begin
                    m_state = 0;
                end
            end
        end
    end

    always @(negedge clock) begin
        chk("cyc_state",  int'(state),        m_state);
        chk("cyc_pc",     int'(pc),           m_pc);
        chk("cyc_opcode", int'(opcode),       m_op);
        chk("cyc_fetch",  int'(fetch_req),    (m_state == 0) ? 1 : 0);
        chk("cyc_taken",  int'(branch_taken), m_taken);
        chk("cyc_done",   int'(instr_done),   m_done);
        chk("cyc_ill",    int'(illegal_op),   m_ill);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic fetch(input logic [15:0] w);
        instr_word  = w;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; instr_word = '0; instr_valid = 1'b0;
        LT_flag = 1'b0; sm_reset = 1'b0; halt = 1'b0;
        tick(); tick();
        chk("rst_state", int'(state), 6);
        chk("rst_pc", int'(pc), 0);
        chk("rst_fetch", int'(fetch_req), 0);
        chk("rst_done", int'(instr_done), 0);
        reset_n = 1'b1;
        tick();
        chk("exit_state", int'(state), 0);

        // 1: ADD
        fetch(16'h6123);
        chk("add_s1", int'(state), 1); chk("add_pc", int'(pc), 1); chk("add_op", int'(opcode), 6);
        tick(); chk("add_s2", int'(state), 2);
        tick(); chk("add_s3", int'(state), 3);
        tick(); chk("add_s6", int'(state), 6); chk("add_done", int'(instr_done), 1);
        tick(); chk("add_s0", int'(state), 0); chk("add_pc_end", int'(pc), 1);

        // 2: JMP to 0x20, then JMP 0x10A5
        fetch(16'h1020); tick(); tick();
        chk("jmp0_pc", int'(pc), 8'h20);
        fetch(16'h10A5);
        chk("jmp_s1", int'(state), 1); chk("jmp_pc1", int'(pc), 8'h21);
        tick(); chk("jmp_s6", int'(state), 6); chk("jmp_taken", int'(branch_taken), 1);
        chk("jmp_pc6", int'(pc), 8'h21);
        tick(); chk("jmp_pc", int'(pc), 8'hA5); chk("jmp_taken_off", int'(branch_taken), 0);

        // 3: BLT taken then not taken
        fetch(16'h5040);
        tick(); chk("blt_s2", int'(state), 2); LT_flag = 1'b1;
        tick(); LT_flag = 1'b0; chk("blt_taken", int'(branch_taken), 1);
        tick(); chk("blt_pc", int'(pc), 8'h40);
        fetch(16'h5040);
        tick(); LT_flag = 1'b0;
        tick(); chk("bltn_s6", int'(state), 6); chk("bltn_taken", int'(branch_taken), 0);
        tick(); chk("bltn_pc", int'(pc), 8'h41);

        // 4: wrap and illegal opcode
        fetch(16'h10FF); tick(); tick();
        chk("wrap_pre", int'(pc), 8'hFF);
        fetch(16'h0000);
        chk("nop_s6", int'(state), 6); chk("wrap_pc", int'(pc), 0);
        tick(); chk("nop_s0", int'(state), 0);
        fetch(16'hA000);
        chk("ill_pulse", int'(illegal_op), 1); chk("ill_op", int'(opcode), 0);
        chk("ill_s6", int'(state), 6);
        tick(); chk("ill_off", int'(illegal_op), 0);

        // fetch dropped by sm_reset
        sm_reset = 1'b1; fetch(16'h6000); sm_reset = 1'b0;
        chk("drop_s6", int'(state), 6); chk("drop_pc", int'(pc), 1);
        chk("drop_op", int'(opcode), 0); chk("drop_done", int'(instr_done), 1);
        tick();

        // halt in state 0 does not block the pending fetch
        halt = 1'b1;
        tick(); chk("halt_wait", int'(state), 0);
        fetch(16'h0000); chk("halt_nop", int'(state), 6);
        tick(); chk("halt_s7", int'(state), 7); chk("halt_fetch", int'(fetch_req), 0);
        tick(); chk("halt_hold", int'(state), 7);
        halt = 1'b0;
        tick(); chk("halt_exit", int'(state), 0); chk("halt_pc", int'(pc), 2);

        // 5: LDW aborted in state 2, then LDW halted at retire
        fetch(16'h2011);
        tick(); chk("abort_s2", int'(state), 2); sm_reset = 1'b1;
        tick(); sm_reset = 1'b0;
        chk("abort_s6", int'(state), 6); chk("abort_done", int'(instr_done), 1);
        chk("abort_pc", int'(pc), 3);
        tick();
        fetch(16'h2011);
        tick(); tick(); chk("ldw_s3", int'(state), 3); halt = 1'b1;
        tick(); chk("ldw_s6", int'(state), 6);
        tick(); chk("ldw_s7", int'(state), 7); chk("ldw_op7", int'(opcode), 0);
        tick(); chk("ldw_hold", int'(state), 7);
        halt = 1'b0;
        tick(); chk("ldw_exit", int'(state), 0); chk("ldw_pc", int'(pc), 4);

        // 6: async reset mid-LDW
        fetch(16'h2022);
        tick(); chk("ar_s2", int'(state), 2);
        #1 reset_n = 1'b0;
        #1;
        chk("ar_state", int'(state), 6); chk("ar_pc", int'(pc), 0);
        chk("ar_op", int'(opcode), 0); chk("ar_fetch", int'(fetch_req), 0);
        tick();
        reset_n = 1'b1;
        tick(); chk("ar_exit", int'(state), 0); chk("ar_done", int'(instr_done), 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
